// File: rtl/m_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// m_muldiv_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - R-type funct codes for mult/multu/div/divu and mthi/mtlo
//   - FSM state encoding
//   - latched operation type plus a small classification helper
// ---------------------------------------------------------------------------
package m_muldiv_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MUL_S = 2'd0,
    MUL_U = 2'd1,
    DIV_S = 2'd2,
    DIV_U = 2'd3
  } op_t;

  function automatic logic is_div_op(input op_t op);
    return (op == DIV_S) || (op == DIV_U);
  endfunction

endpackage

// File: rtl/m_muldiv_iter_dp.sv
// ---------------------------------------------------------------------------
// m_muldiv_iter_dp
// Combinational single-bit step of the multiply/divide datapath on a 2N-bit
// working register.
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : working register; multiply {partial, multiplier},
//              divide {remainder, dividend/quotient}
//   operand  : multiplicand (multiply) or divisor (divide), magnitude
//   acc_next : working register after one step
// ---------------------------------------------------------------------------
module m_muldiv_iter_dp #(
  parameter int N = 32
) (
  input  logic           is_div,
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   operand,
  output logic [2*N-1:0] acc_next
);

  logic [N:0] sum;
  logic [N:0] rem_sh;
  logic [N:0] diff;

  always_comb begin
    // N+1 bits keep the multiply carry, which is shifted back into the MSB.
    sum    = {1'b0, acc[2*N-1:N]} + {1'b0, operand};
    // Remainder shifted left with the next dividend bit appended.
    rem_sh = acc[2*N-1:N-1];
    // Bit N of the difference is the borrow: set means the trial went negative.
    diff   = rem_sh - {1'b0, operand};
    acc_next = '0;
    if (is_div) begin
      if (!diff[N]) begin
        acc_next = {diff[N-1:0], acc[N-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[N-1:0], acc[N-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum, acc[N-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*N-1:1]};
    end
  end

endmodule

// File: rtl/m_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// m_muldiv_sequencer
// Multi-cycle HI/LO multiply/divide unit beside the EX-stage ALU.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start, fn_field     : EX request and R-type funct (mult/multu/div/divu)
//   op_a, op_b          : rs / rt operands
//   kill                : pipeline flush, aborts an operation in ITER/FIX
//   wr_hi, wr_lo, wdata : mthi / mtlo writes, honoured only when not busy
//   busy                : operation in progress (stall to hazard unit)
//   done                : one-cycle pulse after HI/LO commit
//   div_zero            : sticky divide-by-zero flag, cleared by next start
//   hi, lo              : HI / LO registers
// Latency: start at edge 0, N iteration edges, one fix edge, done visible
// in the cycle after edge N+1.
// ---------------------------------------------------------------------------
module m_muldiv_sequencer
  import m_muldiv_pkg::*;
#(
  parameter int N          = 32,
  parameter int N_FN_FIELD = 6,
  parameter int N_CNT      = 6   // 2**N_CNT must exceed N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_FN_FIELD-1:0] fn_field,
  input  logic [N-1:0]          op_a,
  input  logic [N-1:0]          op_b,
  input  logic                  kill,
  input  logic                  wr_hi,
  input  logic                  wr_lo,
  input  logic [N-1:0]          wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [N-1:0]          hi,
  output logic [N-1:0]          lo
);

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t           state_reg;
  op_t              op_reg;
  logic [N_CNT-1:0] cnt_reg;
  logic [2*N-1:0]   acc_reg;
  logic [2*N-1:0]   acc_step;
  logic [N-1:0]     operand_reg;
  logic [N-1:0]     op_a_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             div_zero_reg;
  logic [N-1:0]     hi_reg;
  logic [N-1:0]     lo_reg;

  // Request decode
  logic [5:0] fn6;
  logic       fn_valid;
  op_t        fn_op;
  logic       signed_op;
  logic       sa;
  logic       sb;
  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;
  logic       accept;

  assign fn6 = 6'(fn_field);

  always_comb begin
    fn_valid = 1'b1;
    fn_op    = MUL_U;
    case (fn6)
      FN_MULT:  fn_op = MUL_S;
      FN_MULTU: fn_op = MUL_U;
      FN_DIV:   fn_op = DIV_S;
      FN_DIVU:  fn_op = DIV_U;
      default:  fn_valid = 1'b0;
    endcase
  end

  assign signed_op = (fn_op == MUL_S) || (fn_op == DIV_S);
  assign sa        = signed_op & op_a[N-1];
  assign sb        = signed_op & op_b[N-1];
  assign mag_a     = sa ? -op_a : op_a;
  assign mag_b     = sb ? -op_b : op_b;

  // kill beats a simultaneous start; DONE accepts back-to-back like IDLE.
  assign accept = start && fn_valid && !kill &&
                  ((state_reg == IDLE) || (state_reg == DONE));

  m_muldiv_iter_dp #(.N(N)) u_iter_dp (
    .is_div   (is_div_op(op_reg)),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (acc_step)
  );

  // Sign fix-up applied on the FIX->DONE edge
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quo_fix  = neg_q_reg ? -acc_reg[N-1:0] : acc_reg[N-1:0];
    rem_fix  = neg_r_reg ? -acc_reg[2*N-1:N] : acc_reg[2*N-1:N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= MUL_S;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      operand_reg  <= '0;
      op_a_reg     <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      if (!busy_reg && wr_hi) hi_reg <= wdata;
      if (!busy_reg && wr_lo) lo_reg <= wdata;

      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            state_reg    <= ITER;
            busy_reg     <= 1'b1;
            div_zero_reg <= 1'b0;
            op_reg       <= fn_op;
            cnt_reg      <= N_CNT'(N);
            op_a_reg     <= op_a;
            neg_q_reg    <= sa ^ sb;
            neg_r_reg    <= sa;
            ovf_reg      <= (fn_op == DIV_S) && (op_a == MIN_NEG) && (op_b == '1);
            if (fn_op == DIV_S || fn_op == DIV_U) begin
              acc_reg     <= {{N{1'b0}}, mag_a};
              operand_reg <= mag_b;
            end else begin
              acc_reg     <= {{N{1'b0}}, mag_b};
              operand_reg <= mag_a;
            end
          end else begin
            state_reg <= IDLE;
          end
        end

        ITER: begin
          if (kill) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_reg <= acc_step;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == N_CNT'(1)) state_reg <= FIX;
          end
        end

        FIX: begin
          if (kill) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            // Commit overrides any mthi/mtlo on this edge (busy is still high).
            if (is_div_op(op_reg)) begin
              if (operand_reg == '0) begin
                lo_reg       <= '1;
                hi_reg       <= op_a_reg;
                div_zero_reg <= 1'b1;
              end else if (ovf_reg) begin
                lo_reg <= MIN_NEG;
                hi_reg <= '0;
              end else begin
                lo_reg <= quo_fix;
                hi_reg <= rem_fix;
              end
            end else begin
              hi_reg <= prod_fix[2*N-1:N];
              lo_reg <= prod_fix[N-1:0];
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_m_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_m_muldiv_sequencer
// Directed self-checking bench for m_muldiv_sequencer (N = 32).
// ---------------------------------------------------------------------------
module tb_m_muldiv_sequencer;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  fn_field;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  m_muldiv_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .fn_field (fn_field),
    .op_a     (op_a),
    .op_b     (op_b),
    .kill     (kill),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 unit after the start edge.
  task automatic start_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    fn_field = fn;
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges from the start edge until done is seen (0 if never), and busy cycles.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    if (busy) busy_cycles++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %0b want 0", div_zero); end
    checks++; if (hi !== 32'h0)      begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0)      begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_mthi_kill();
    int dn;
    wr_hi = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi got %h want 00001234", hi); end
    // kill together with start in IDLE drops the start
    kill = 1'b1;
    start_op(F_MULTU, 32'd5, 32'd6);
    kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_start_same_cycle busy got %0b want 0", busy); end
    start_op(F_MULTU, 32'd5, 32'd6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_rise got %0b want 1", busy); end
    wr_lo = 1'b1;
    wdata = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    wr_lo = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %0b want 0", busy); end
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dn++;
      @(posedge clk);
      #1;
    end
    checks++; if (dn !== 0)              begin errors++; $display("FAIL kill_no_done got %0d pulses want 0", dn); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL kill_hi got %h want 00001234", hi); end
    checks++; if (lo !== 32'h0)         begin errors++; $display("FAIL kill_wr_lo_busy lo got %h want 0", lo); end
    $display("mthi+kill: hi=%h lo=%h busy=%0b done_pulses=%0d", hi, lo, busy, dn);
  endtask

  task automatic test_multu();
    int e, b;
    start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL multu_done_edge got %0d want 33", e); end
    checks++; if (b !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", b); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_width got %0b want 0", done); end
    $display("multu ffffffff*ffffffff: hi=%h lo=%h edge=%0d busy=%0d", hi, lo, e, b);
  endtask

  task automatic test_mult();
    int e, b;
    start_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(e, b);
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    $display("mult -3*7: hi=%h lo=%h edge=%0d", hi, lo, e);
  endtask

  task automatic test_div_and_zero();
    int e, b;
    start_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(e, b);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    $display("div -7/2: hi=%h lo=%h edge=%0d", hi, lo, e);
    @(posedge clk);
    #1;
    start_op(F_DIVU, 32'd100, 32'd0);
    wait_done(e, b);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h want ffffffff", lo); end
    checks++; if (hi !== 32'd100)       begin errors++; $display("FAIL divz_hi got %h want 00000064", hi); end
    checks++; if (div_zero !== 1'b1)    begin errors++; $display("FAIL divz_flag got %0b want 1", div_zero); end
    $display("divu 100/0: hi=%h lo=%h div_zero=%0b", hi, lo, div_zero);
    @(posedge clk);
    #1;
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divz_sticky got %0b want 1", div_zero); end
    start_op(F_MULTU, 32'd2, 32'd3);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divz_clear got %0b want 0", div_zero); end
    wait_done(e, b);
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL multu_2x3_lo got %h want 00000006", lo); end
    $display("multu 2*3 after div0: hi=%h lo=%h div_zero=%0b", hi, lo, div_zero);
  endtask

  task automatic test_back_to_back();
    int e, b;
    @(posedge clk);
    #1;
    start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e, b);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0)         begin errors++; $display("FAIL ovf_hi got %h want 0", hi); end
    checks++; if (div_zero !== 1'b0)    begin errors++; $display("FAIL ovf_div_zero got %0b want 0", div_zero); end
    $display("div 80000000/-1: hi=%h lo=%h", hi, lo);
    // Issued while done is high
    start_op(F_DIVU, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0b want 1", busy); end
    wait_done(e, b);
    checks++; if (e !== 33)       begin errors++; $display("FAIL b2b_done_edge got %0d want 33", e); end
    checks++; if (lo !== 32'd14)  begin errors++; $display("FAIL b2b_lo got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2)   begin errors++; $display("FAIL b2b_hi got %h want 00000002", hi); end
    $display("b2b divu 100/7: hi=%h lo=%h edge=%0d", hi, lo, e);
  endtask

  task automatic test_async_reset();
    int e, b;
    @(posedge clk);
    #1;
    start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %0b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL arst_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL arst_done got %0b want 0", done); end
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL arst_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL arst_lo got %h want 0", lo); end
    $display("async reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
    #1;
    rst_n = 1'b1;
    fn_field = F_MULTU;
    op_a = 32'd7;
    op_b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(e, b);
    checks++; if (e !== 33)      begin errors++; $display("FAIL arst_restart_edge got %0d want 33", e); end
    checks++; if (lo !== 32'd63) begin errors++; $display("FAIL arst_restart_lo got %h want 0000003f", lo); end
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL arst_restart_hi got %h want 0", hi); end
    $display("restart multu 7*9: hi=%h lo=%h edge=%0d", hi, lo, e);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    fn_field = 6'd0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    kill     = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    wdata    = 32'd0;
    test_reset();
    test_mthi_kill();
    test_multu();
    test_mult();
    test_div_and_zero();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
